prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the 256x16 instruction memory that the pipelined CPU fetches from.
//  Receives a framed byte stream over a valid/ready port and assembles 16-bit instruction words.
//  Writes the words to consecutive addresses from 0, checks a frame checksum, and holds the CPU
//  in reset until a good program is loaded.
//  Word format: [7:0] = opcode, [15:8] = operand. Low byte is sent first.
// PARAMETERS
//  ADDR_W   8   instruction memory address width; must be >= 8; bits above [7:0] always drive 0
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       1-cycle pulse; begins a new load session from any state
//  in_valid   in   1       byte on in_data is valid
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts in_data this cycle; accept = in_valid & in_ready
//  mem_we     out  1       1-cycle write strobe to instruction memory
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  16      write data {operand, opcode}
//  cpu_hold   out  1       high = hold CPU in reset; low only after a good load
//  busy       out  1       session in progress (states COUNT, LO, HI, CSUM)
//  done       out  1       last session loaded with correct checksum
//  err        out  1       last session failed its checksum
// BEHAVIOUR
//  Frame format: byte N, then 2*W payload bytes (lo,hi per word), then checksum byte C.
//   W = N, except N == 0 means W = 256.
//   C is chosen so that N ^ all payload bytes ^ C == 8'h00.
//  Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0,
//   err=0. Internal state goes to IDLE, word counter and checksum accumulator go to 0.
//   All take effect immediately on reset assertion, without waiting for a clock edge.
//  States:
//   IDLE  start -> COUNT
//   COUNT accept: store W, acc = byte, addr = 0 -> LO
//   LO    accept: latch lo byte, acc ^= byte -> HI
//   HI    accept: acc ^= byte, schedule write; -> CSUM if this is word W, else -> LO
//   CSUM  accept: if (acc ^ byte) == 0 -> DONE, else -> ERR
//   DONE  start -> COUNT
//   ERR   start -> COUNT
//  in_ready = 1 in COUNT, LO, HI and CSUM, and 0 in every other state.
//   in_ready is also forced to 0 in any cycle where start = 1.
//  Write timing: on the edge that accepts a HI byte, register mem_we=1, mem_addr=addr and
//   mem_wdata={hi,lo}. mem_we drops to 0 on the next edge; mem_addr and mem_wdata hold their values.
//   addr increments after each write. Back-to-back bytes (in_valid held high) are sustained at
//   1 byte/cycle with no bubbles.
//  addr never wraps within a session: with W = 256 the last write goes to address 255.
//  Outputs decoded from the state register:
//   cpu_hold = (state != DONE), busy, done, err.
//   So cpu_hold falls the cycle after the checksum byte is accepted, which is always after the
//   last mem_we pulse.
//  start in any state, including mid-session:
//   next state = COUNT, addr = 0, acc = 0, done = 0, err = 0, cpu_hold = 1.
//   Memory words already written are not undone.
//  start together with in_valid: start wins and the byte is not accepted.
//  in_valid is ignored in IDLE, DONE and ERR. in_data is don't-care whenever in_valid = 0.
//  Reset mid-session abandons the frame; the loader returns to IDLE with cpu_hold = 1.
// TESTING
//  Good load: start; bytes 02,01,05,03,00,05 back-to-back
//   -> writes [0]=0x0501 and [1]=0x0003; done=1, cpu_hold=0 one cycle after the last byte; err=0.
//  Bad checksum: same frame with final byte 06
//   -> both writes still occur; err=1, done=0, cpu_hold stays 1.
//  Full image: N=00, 512 payload bytes, correct C
//   -> 256 writes to addr 0..255 in order; no write at any other address; done=1.
//  Gaps and ignored input:
//   in_valid toggled with random idle cycles -> same writes and result as the back-to-back case.
//   in_valid driven in IDLE or DONE -> in_ready=0 and no writes.
//  Restart mid-load: start after the first word is written, then a fresh 1-word frame
//   -> that frame's word is written to addr 0; done=1.
//  Async reset: assert reset mid-HI, between clock edges
//   -> outputs take their reset values immediately; after release the loader is in IDLE and
//   ignores bytes until start.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader side; the master modport is the byte source / memory side.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    // A byte moves when in_valid and in_ready are both high at a rising clk edge.
    // in_data is meaningful only while in_valid is high. in_valid may be raised or dropped freely.
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed, checksummed byte stream into the 256x16 instruction memory and
// keeps the CPU in reset until a complete frame with a good checksum has been written.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        last_q, last_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        lo_q, lo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;

    logic              in_session;
    logic              in_ready_c;
    logic              accept;

    assign in_session = (state_q == S_COUNT) || (state_q == S_LO) ||
                        (state_q == S_HI)    || (state_q == S_CSUM);
    // start always takes priority over a byte offered in the same cycle.
    assign in_ready_c = in_session && !start;
    assign accept     = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 8'd0;
            addr_q      <= 8'd0;
            acc_q       <= 8'd0;
            lo_q        <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (start) begin
            state_d = S_COUNT;
            addr_d  = 8'd0;
            acc_d   = 8'd0;
        end else if (accept) begin
            unique case (state_q)
                S_COUNT: begin
                    // Index of the final word; N == 0 wraps to 255, i.e. 256 words.
                    last_d  = bus.in_data - 8'd1;
                    acc_d   = bus.in_data;
                    addr_d  = 8'd0;
                    state_d = S_LO;
                end
                S_LO: begin
                    lo_d    = bus.in_data;
                    acc_d   = acc_q ^ bus.in_data;
                    state_d = S_HI;
                end
                S_HI: begin
                    acc_d       = acc_q ^ bus.in_data;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(addr_q);
                    mem_wdata_d = {bus.in_data, lo_q};
                    if (addr_q == last_q) begin
                        state_d = S_CSUM;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = S_LO;
                    end
                end
                S_CSUM: begin
                    state_d = ((acc_q ^ bus.in_data) == 8'd0) ? S_DONE : S_ERR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign cpu_hold  = (state_q != S_DONE);
    assign busy      = in_session;
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized frames driven over the byte port, writes checked
// against an expected queue built from the frame contents, outcome flags checked per frame.
module tb_prog_loader;
    localparam int ADDR_W = 8;
    localparam int EW     = ADDR_W + 16;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int passes = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    frame_q[$];
    bit            exp_good;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard: every write must be the next expected one ----------------
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (reset === 1'b0 && bus.mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== exp)
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, exp[EW-1:16], exp[15:0]);
                else
                    passes++;
            end
        end
    end

    // ---------------- reference model ----------------
    // Builds a frame of n words (n == 0 means 256) with random payload; queues the writes
    // it must produce and whether its checksum is good.
    task automatic make_frame(input int n, input bit corrupt);
        int         w;
        logic [7:0] x;
        logic [15:0] word;
        w = (n == 0) ? 256 : n;
        frame_q.delete();
        frame_q.push_back(8'(n));
        for (int i = 0; i < w; i++) begin
            word = 16'($urandom);
            frame_q.push_back(word[7:0]);
            frame_q.push_back(word[15:8]);
            exp_q.push_back({ADDR_W'(i), word});
        end
        x = 8'd0;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
        x = 8'd0;
        foreach (frame_q[i]) x ^= frame_q[i];
        exp_good = (x == 8'd0);
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int gap_max);
        int gaps;
        for (int i = 0; i < frame_q.size(); i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = frame_q[i];
            wait_accept();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drive_ignored(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0)
                $display("FAIL %s_in_ready: got %b, required 0", name, bus.in_ready);
            else
                passes++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        #2 reset = 1'b1;
        #1;
        checks += 8;
        if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); else passes++;
        if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b, required 0", bus.mem_we); else passes++;
        if (bus.mem_addr !== '0) $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr); else passes++;
        if (bus.mem_wdata !== 16'h0) $display("FAIL rst_mem_wdata: got %h, required 0", bus.mem_wdata); else passes++;
        if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b, required 1", cpu_hold); else passes++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else passes++;
        if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else passes++;
        if (err !== 1'b0) $display("FAIL rst_err: got %b, required 0", err); else passes++;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_ignored_idle();
        drive_ignored(5, "idle");
    endtask

    task automatic test_good_load();
        pulse_start();
        frame_q = '{8'h02, 8'h01, 8'h05, 8'h03, 8'h00, 8'h05};
        exp_q.push_back({ADDR_W'(0), 16'h0501});
        exp_q.push_back({ADDR_W'(1), 16'h0003});
        send_frame(0);
        checks += 5;
        if (done !== 1'b1) $display("FAIL good_done: got %b, required 1", done); else passes++;
        if (cpu_hold !== 1'b0) $display("FAIL good_cpu_hold: got %b, required 0", cpu_hold); else passes++;
        if (err !== 1'b0) $display("FAIL good_err: got %b, required 0", err); else passes++;
        if (busy !== 1'b0) $display("FAIL good_busy: got %b, required 0", busy); else passes++;
        if (exp_q.size() != 0) $display("FAIL good_writes_left: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_ignored_done();
        drive_ignored(5, "done");
        checks++;
        if (done !== 1'b1) $display("FAIL done_kept: got %b, required 1", done); else passes++;
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        frame_q = '{8'h02, 8'h01, 8'h05, 8'h03, 8'h00, 8'h06};
        exp_q.push_back({ADDR_W'(0), 16'h0501});
        exp_q.push_back({ADDR_W'(1), 16'h0003});
        send_frame(0);
        checks += 4;
        if (err !== 1'b1) $display("FAIL bad_err: got %b, required 1", err); else passes++;
        if (done !== 1'b0) $display("FAIL bad_done: got %b, required 0", done); else passes++;
        if (cpu_hold !== 1'b1) $display("FAIL bad_cpu_hold: got %b, required 1", cpu_hold); else passes++;
        if (exp_q.size() != 0) $display("FAIL bad_writes_left: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_full_image();
        pulse_start();
        make_frame(0, 1'b0);
        send_frame(0);
        checks += 3;
        if (done !== 1'b1) $display("FAIL full_done: got %b, required 1", done); else passes++;
        if (cpu_hold !== 1'b0) $display("FAIL full_cpu_hold: got %b, required 0", cpu_hold); else passes++;
        if (exp_q.size() != 0) $display("FAIL full_writes_left: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_gaps();
        bit corrupt;
        // The fixed frame first, then random ones, all with random idle cycles between bytes.
        pulse_start();
        frame_q = '{8'h02, 8'h01, 8'h05, 8'h03, 8'h00, 8'h05};
        exp_q.push_back({ADDR_W'(0), 16'h0501});
        exp_q.push_back({ADDR_W'(1), 16'h0003});
        exp_good = 1'b1;
        for (int it = 0; it < 8; it++) begin
            if (it > 0) begin
                pulse_start();
                corrupt = ($urandom_range(2, 0) == 0);
                make_frame(int'($urandom_range(8, 1)), corrupt);
            end
            send_frame(3);
            checks += 4;
            if (done !== exp_good) $display("FAIL gap%0d_done: got %b, required %b", it, done, exp_good); else passes++;
            if (err !== !exp_good) $display("FAIL gap%0d_err: got %b, required %b", it, err, !exp_good); else passes++;
            if (cpu_hold !== !exp_good) $display("FAIL gap%0d_cpu_hold: got %b, required %b", it, cpu_hold, !exp_good); else passes++;
            if (exp_q.size() != 0) $display("FAIL gap%0d_writes_left: got %0d, required 0", it, exp_q.size()); else passes++;
        end
    endtask

    task automatic test_restart();
        logic [7:0] partial[$];
        pulse_start();
        checks += 3;
        if (done !== 1'b0) $display("FAIL restart_done_clr: got %b, required 0", done); else passes++;
        if (cpu_hold !== 1'b1) $display("FAIL restart_hold_set: got %b, required 1", cpu_hold); else passes++;
        if (busy !== 1'b1) $display("FAIL restart_busy: got %b, required 1", busy); else passes++;
        make_frame(3, 1'b0);
        partial = frame_q[0:2];
        frame_q = partial;
        exp_q = exp_q[0:0];
        send_frame(0);
        // start arrives with a byte offered in the same cycle; the byte must be refused.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        start = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL restart_start_wins: got %b, required 0", bus.in_ready); else passes++;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        checks += 2;
        if (exp_q.size() != 0) $display("FAIL restart_first_word: got %0d left, required 0", exp_q.size()); else passes++;
        if (busy !== 1'b1) $display("FAIL restart_busy2: got %b, required 1", busy); else passes++;
        make_frame(1, 1'b0);
        send_frame(0);
        checks += 2;
        if (done !== 1'b1) $display("FAIL restart_done: got %b, required 1", done); else passes++;
        if (exp_q.size() != 0) $display("FAIL restart_writes_left: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_async_reset();
        logic [7:0] partial[$];
        pulse_start();
        make_frame(3, 1'b0);
        partial = frame_q[0:5];
        frame_q = partial;
        send_frame(0);
        // Loader now waits for the hi byte of word 2; assert reset between clock edges.
        void'(exp_q.pop_back());
        #3 reset = 1'b1;
        #1;
        checks += 9;
        if (bus.in_ready !== 1'b0) $display("FAIL areset_in_ready: got %b, required 0", bus.in_ready); else passes++;
        if (bus.mem_we !== 1'b0) $display("FAIL areset_mem_we: got %b, required 0", bus.mem_we); else passes++;
        if (bus.mem_addr !== '0) $display("FAIL areset_mem_addr: got %h, required 0", bus.mem_addr); else passes++;
        if (bus.mem_wdata !== 16'h0) $display("FAIL areset_mem_wdata: got %h, required 0", bus.mem_wdata); else passes++;
        if (cpu_hold !== 1'b1) $display("FAIL areset_cpu_hold: got %b, required 1", cpu_hold); else passes++;
        if (busy !== 1'b0) $display("FAIL areset_busy: got %b, required 0", busy); else passes++;
        if (done !== 1'b0) $display("FAIL areset_done: got %b, required 0", done); else passes++;
        if (err !== 1'b0) $display("FAIL areset_err: got %b, required 0", err); else passes++;
        if (exp_q.size() != 0) $display("FAIL areset_writes_left: got %0d, required 0", exp_q.size()); else passes++;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_ignored(4, "post_reset");
        pulse_start();
        make_frame(2, 1'b0);
        send_frame(1);
        checks += 2;
        if (done !== 1'b1) $display("FAIL areset_reload_done: got %b, required 1", done); else passes++;
        if (exp_q.size() != 0) $display("FAIL areset_reload_left: got %0d, required 0", exp_q.size()); else passes++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ignored_idle();
        test_good_load();
        test_ignored_done();
        test_bad_checksum();
        test_full_image();
        test_gaps();
        test_restart();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
